// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared types for the alu_seq block.
//   alu_op_e : 4-bit opcode. 0..3 keep the legacy 2-bit ALU encodings.
//              Codes 11..15 are illegal.
//   state_e  : handshake FSM states.
//   ALU_OP_W : opcode width.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if : issue-side and writeback-side handshake bundle of alu_seq.
//   in_valid/in_ready, A, B, op          : operand request from issue
//   out_valid/out_ready, result, flags   : response toward writeback
//   master modport : the issue/writeback side driving requests
//   slave  modport : the ALU itself
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              A;
    logic [WIDTH-1:0]              B;
    logic [alu_pkg::ALU_OP_W-1:0]  op;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              result;
    logic                          zero;
    logic                          neg;
    logic                          carry;
    logic                          ovf;
    logic                          err;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero, neg, carry, ovf, err
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero, neg, carry, ovf, err
    );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter : unsigned shift-add multiplier, one multiplier bit per clock,
// LSB first. Returns the low WIDTH bits of the product.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load operands and begin (counter = WIDTH)
//   i_a, i_b   : multiplicand, multiplier
//   o_done     : one-cycle pulse once all WIDTH bits have been consumed
//   o_product  : accumulated product, valid while o_done is high
// Latency is fixed at WIDTH step cycles regardless of operand values.
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= CNT_W'(WIDTH);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt != '0) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                // Counter already drained: the done pulse was seen this cycle.
                r_active <= 1'b0;
            end
        end
    end

    assign o_done    = r_active && (r_cnt == '0);
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : handshaked ALU with registered result and NZCV-style flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave
//                in_valid/in_ready/A/B/op      request side
//                out_valid/out_ready/result/zero/neg/carry/ovf/err  response
// Single-cycle ops have latency 1 and can stream one per cycle when the
// consumer is ready. in_ready is the only combinational output.
// Build option ALU_SEQ_MUL_EN: adds the iterative multiplier (opcode 10,
// latency WIDTH+1). Without it opcode 10 is reported as illegal.
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_neg;
    logic              r_carry;
    logic              r_ovf;
    logic              r_err;

    alu_op_e           w_op;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]    w_add;
    logic [WIDTH:0]    w_sub;
    logic [WIDTH-1:0]  w_res;
    logic              w_zero;
    logic              w_neg;
    logic              w_carry;
    logic              w_ovf;
    logic              w_err;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_mul;

    assign w_op    = alu_op_e'(bus.op);
    assign w_shamt = bus.B[SHAMT_W-1:0];

`ifdef ALU_SEQ_MUL_EN
    logic              w_mul_done;
    logic [WIDTH-1:0]  w_product;

    assign w_is_mul = (bus.op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_a       (bus.A),
        .i_b       (bus.B),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    // Single-cycle datapath. SUB is A + ~B + 1 so carry=1 means no borrow.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_add   = {1'b0, bus.A} + {1'b0, bus.B};
        w_sub   = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        case (w_op)
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (bus.A[MSB] == bus.B[MSB]) && (w_res[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (bus.A[MSB] != bus.B[MSB]) && (w_res[MSB] != bus.A[MSB]);
            end
            OP_AND:  w_res = bus.A & bus.B;
            OP_OR:   w_res = bus.A | bus.B;
            OP_XOR:  w_res = bus.A ^ bus.B;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  w_res = bus.A << w_shamt;
            OP_SRL:  w_res = bus.A >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(bus.A) >>> w_shamt);
            // Illegal codes, and MUL when the multiplier is not built.
            default: w_err = 1'b1;
        endcase
        w_zero = (w_res == '0);
        w_neg  = w_res[MSB];
    end

    // Next-state and in_ready.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = w_is_mul ? BUSY : DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (w_mul_done) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_state_next = w_is_mul ? BUSY : DONE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= w_zero;
                r_neg       <= w_neg;
                r_carry     <= w_carry;
                r_ovf       <= w_ovf;
                r_err       <= w_err;
            end else if (w_accept && w_is_mul) begin
                // Previous result consumed this cycle; nothing valid until MUL ends.
                r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            end else if ((r_state == BUSY) && w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_product;
                r_zero      <= (w_product == '0);
                r_neg       <= w_product[MSB];
                r_carry     <= 1'b0;
                r_ovf       <= 1'b0;
                r_err       <= 1'b0;
`endif
            end else if ((r_state == DONE) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;

endmodule
